// File: rtl/mode_controller_if.sv
// Control/status bundle between the front-panel mode controller and its
// sample engine. The controller uses the slave modport; stimulus uses master.
interface mode_controller_if #(
  parameter int NUM_CH = 8,
  parameter int ADDR_W = 23
);
  logic [3:0]        i_btn;
  logic [NUM_CH-1:0] i_sel_src;
  logic [NUM_CH-1:0] i_sel_dst;
  logic [NUM_CH-1:0] i_loop;
  logic [1:0]        i_speed;
  logic              i_op_done;

  logic [1:0]        o_mode;
  logic              o_busy;
  logic              o_start;
  logic              o_stop;
  logic [ADDR_W-1:0] o_src_addr;
  logic [ADDR_W-1:0] o_dst_addr;
  logic              o_dst_en;
  logic [NUM_CH-1:0] o_mix_mask;
  logic [NUM_CH-1:0] o_loop_mask;
  logic [1:0]        o_speed;
  logic              o_err;
  logic              o_timeout;

  modport master (
    output i_btn, i_sel_src, i_sel_dst, i_loop, i_speed, i_op_done,
    input  o_mode, o_busy, o_start, o_stop, o_src_addr, o_dst_addr, o_dst_en,
           o_mix_mask, o_loop_mask, o_speed, o_err, o_timeout
  );

  modport slave (
    input  i_btn, i_sel_src, i_sel_dst, i_loop, i_speed, i_op_done,
    output o_mode, o_busy, o_start, o_stop, o_src_addr, o_dst_addr, o_dst_en,
           o_mix_mask, o_loop_mask, o_speed, o_err, o_timeout
  );
endinterface

// File: rtl/mode_controller.sv
// Button-driven REC/PLAY/MIX sequencer: IDLE -> ARM -> RUN -> DRAIN -> IDLE.
// Define MODE_CTRL_WDT_EN to enable the DRAIN watchdog (o_timeout).
module mode_controller #(
  parameter int NUM_CH     = 8,
  parameter int CHUNK_LOG2 = 20,
  parameter int ADDR_W     = 23,
  parameter int WDT_CYCLES = 1024
) (
  input logic          i_clk,
  input logic          i_rst_n,
  mode_controller_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN} state_t;

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_REC  = 2'd1;
  localparam logic [1:0] M_PLAY = 2'd2;
  localparam logic [1:0] M_MIX  = 2'd3;

  state_t            state_q, state_d;
  logic [3:0]        btn_prev_q, btn_prev_d;
  logic [1:0]        mode_q, mode_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic              stop_q, stop_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic              dst_en_q, dst_en_d;
  logic [NUM_CH-1:0] mix_mask_q, mix_mask_d;
  logic [NUM_CH-1:0] loop_mask_q, loop_mask_d;
  logic [1:0]        speed_q, speed_d;
  logic              err_q, err_d;
  logic              timeout_q, timeout_d;

  logic [3:0]        btn_edge;
  logic [1:0]        req_mode;
  logic              sel_ok;
  logic              clear;

`ifdef MODE_CTRL_WDT_EN
  localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
  logic [WDT_W-1:0]  wdt_cnt_q, wdt_cnt_d;
`endif

  function automatic logic [ADDR_W-1:0] chunk_addr(input logic [NUM_CH-1:0] oh);
    logic [ADDR_W-1:0] a;
    a = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) a = ADDR_W'(i) << CHUNK_LOG2;
    end
    return a;
  endfunction

  // Previous-sample register starts at all-ones so held buttons are not events.
  assign btn_edge = bus.i_btn & ~btn_prev_q;

  always_comb begin
    state_d     = state_q;
    btn_prev_d  = bus.i_btn;
    mode_d      = mode_q;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    src_addr_d  = src_addr_q;
    dst_addr_d  = dst_addr_q;
    dst_en_d    = dst_en_q;
    mix_mask_d  = mix_mask_q;
    loop_mask_d = loop_mask_q;
    speed_d     = speed_q;
    err_d       = 1'b0;
    timeout_d   = 1'b0;
    clear       = 1'b0;
    req_mode    = M_IDLE;
    sel_ok      = 1'b0;
`ifdef MODE_CTRL_WDT_EN
    wdt_cnt_d   = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (btn_edge[3])      req_mode = M_REC;
        else if (btn_edge[2]) req_mode = M_PLAY;
        else if (btn_edge[1]) req_mode = M_MIX;

        sel_ok = ((req_mode == M_MIX) ? (|bus.i_sel_src) : $onehot(bus.i_sel_src)) &&
                 ((bus.i_sel_dst == '0) || $onehot(bus.i_sel_dst));

        if (req_mode != M_IDLE) begin
          if (sel_ok) begin
            state_d     = S_ARM;
            start_d     = 1'b1;
            mode_d      = req_mode;
            src_addr_d  = (req_mode == M_MIX) ? '0 : chunk_addr(bus.i_sel_src);
            dst_addr_d  = (req_mode == M_REC) ? '0 : chunk_addr(bus.i_sel_dst);
            dst_en_d    = (req_mode != M_REC) && (bus.i_sel_dst != '0);
            speed_d     = (req_mode == M_PLAY) ? bus.i_speed : 2'd0;
            mix_mask_d  = (req_mode == M_MIX) ? bus.i_sel_src : '0;
            loop_mask_d = (req_mode == M_MIX) ? bus.i_loop : '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ARM: begin
        if (bus.i_op_done) clear = 1'b1;
        else               state_d = S_RUN;
      end
      S_RUN: begin
        // Completion wins over a coincident STOP: no o_stop pulse then.
        if (bus.i_op_done) begin
          clear = 1'b1;
        end else if (btn_edge[0]) begin
          stop_d  = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.i_op_done) begin
          clear = 1'b1;
        end else begin
`ifdef MODE_CTRL_WDT_EN
          if (wdt_cnt_q == WDT_LAST) begin
            clear     = 1'b1;
            timeout_d = 1'b1;
          end else begin
            wdt_cnt_d = wdt_cnt_q + 1'b1;
          end
`endif
        end
      end
      default: clear = 1'b1;
    endcase

    if (clear) begin
      state_d     = S_IDLE;
      mode_d      = M_IDLE;
      src_addr_d  = '0;
      dst_addr_d  = '0;
      dst_en_d    = 1'b0;
      mix_mask_d  = '0;
      loop_mask_d = '0;
      speed_d     = 2'd0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      btn_prev_q  <= 4'b1111;
      mode_q      <= M_IDLE;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      src_addr_q  <= '0;
      dst_addr_q  <= '0;
      dst_en_q    <= 1'b0;
      mix_mask_q  <= '0;
      loop_mask_q <= '0;
      speed_q     <= 2'd0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef MODE_CTRL_WDT_EN
      wdt_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      btn_prev_q  <= btn_prev_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      src_addr_q  <= src_addr_d;
      dst_addr_q  <= dst_addr_d;
      dst_en_q    <= dst_en_d;
      mix_mask_q  <= mix_mask_d;
      loop_mask_q <= loop_mask_d;
      speed_q     <= speed_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
`ifdef MODE_CTRL_WDT_EN
      wdt_cnt_q   <= wdt_cnt_d;
`endif
    end
  end

  assign bus.o_mode      = mode_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_start     = start_q;
  assign bus.o_stop      = stop_q;
  assign bus.o_src_addr  = src_addr_q;
  assign bus.o_dst_addr  = dst_addr_q;
  assign bus.o_dst_en    = dst_en_q;
  assign bus.o_mix_mask  = mix_mask_q;
  assign bus.o_loop_mask = loop_mask_q;
  assign bus.o_speed     = speed_q;
  assign bus.o_err       = err_q;
  assign bus.o_timeout   = timeout_q;

endmodule

// File: doc/mode_controller.md
MODE_CONTROLLER -- requirements
Module: mode_controller

Interface
REQ-001 SHALL have parameter NUM_CH, 8, number of sample chunks/channels (2..16).
REQ-002 SHALL have parameter CHUNK_LOG2, 20, log2 of chunk size in words.
REQ-003 SHALL have parameter ADDR_W, 23, memory address width; ADDR_W >= clog2(NUM_CH)+CHUNK_LOG2.
REQ-004 SHALL have parameter WDT_CYCLES, 1024, drain watchdog limit.
REQ-005 SHALL have port i_clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_btn  in  4  synchronous level buttons; [3]=REC, [2]=PLAY, [1]=MIX, [0]=STOP.
REQ-008 SHALL have port i_sel_src  in  NUM_CH  source chunk select (one-hot for REC/PLAY, mask for MIX).
REQ-009 SHALL have port i_sel_dst  in  NUM_CH  destination chunk select; zero = none.
REQ-010 SHALL have port i_loop  in  NUM_CH  per-channel loop enables for MIX.
REQ-011 SHALL have port i_speed  in  2  playback speed code.
REQ-012 SHALL have port i_op_done  in  1  engine finished current operation.
REQ-013 SHALL have outputs o_mode 2 (0 IDLE, 1 REC, 2 PLAY, 3 MIX), o_busy 1, o_start 1, o_stop 1, o_src_addr ADDR_W, o_dst_addr ADDR_W, o_dst_en 1, o_mix_mask NUM_CH, o_loop_mask NUM_CH, o_speed 2, o_err 1, o_timeout 1; all registered.

Function
REQ-014 SHALL detect button events as rising edges: i_btn[b]=1 while previous sampled value=0.
REQ-015 SHALL implement states IDLE, ARM, RUN, DRAIN; o_busy=1 in every state except IDLE.
REQ-016 SHALL, in IDLE, on simultaneous edges, apply priority REC > PLAY > MIX; STOP edges in IDLE ignored.
REQ-017 SHALL validate on the edge: REC/PLAY need one-hot i_sel_src; MIX needs nonzero i_sel_src; i_sel_dst must be zero or one-hot; failure gives a one-cycle o_err pulse next cycle and stays IDLE.
REQ-018 SHALL, on a valid edge, latch all selections and enter ARM next cycle; o_start=1 exactly during the ARM cycle; RUN follows unconditionally.
REQ-019 SHALL compute chunk address as index << CHUNK_LOG2, zero-extended to ADDR_W.
REQ-020 SHALL drive, per mode: REC: o_src_addr=chunk(i_sel_src), o_dst_en=0. PLAY/MIX: o_dst_addr=chunk(i_sel_dst), o_dst_en=(i_sel_dst!=0). PLAY: o_speed=latched i_speed, else 0. MIX: o_mix_mask=i_sel_src, o_loop_mask=i_loop, else both 0.
REQ-021 SHALL hold latched outputs and o_mode constant from ARM until return to IDLE, regardless of input changes.
REQ-022 SHALL, on STOP edge in RUN, pulse o_stop one cycle and enter DRAIN; REC/PLAY/MIX edges outside IDLE are ignored.
REQ-023 SHALL, on i_op_done in ARM, RUN or DRAIN, enter IDLE next cycle and clear o_mode, masks, addresses, o_dst_en, o_speed.
REQ-024 SHALL, when STOP edge and i_op_done coincide in RUN, enter IDLE without o_stop pulse.

Reset
REQ-025 SHALL, on i_rst_n=0, immediately force IDLE and every output to 0, including mid-operation.
REQ-026 SHALL reset previous-button registers to 4'b1111 so a button held through reset release produces no event.

Configuration
REQ-027 SHALL, with MODE_CTRL_WDT_EN defined, count cycles in DRAIN; at WDT_CYCLES without i_op_done, enter IDLE and pulse o_timeout one cycle.
REQ-028 SHALL, without MODE_CTRL_WDT_EN, tie o_timeout to 0 and wait in DRAIN indefinitely.

Verification (NUM_CH=8, CHUNK_LOG2=20, ADDR_W=23)
REQ-029 SHALL cover: REC edge, i_sel_src=0x04 -> o_start one cycle one clock after edge, o_mode=1, o_src_addr=0x200000, o_dst_en=0; i_op_done -> o_mode=0 next cycle.
REQ-030 SHALL cover: PLAY, src=0x01, dst=0x80, speed=2 -> o_src_addr=0, o_dst_addr=0x700000, o_dst_en=1, o_speed=2; switches toggled in RUN -> outputs unchanged.
REQ-031 SHALL cover: REC with i_sel_src=0x03 -> one o_err pulse, no o_start, o_busy=0.
REQ-032 SHALL cover: MIX src=0x0B, loop=0x02 -> o_mix_mask=0x0B, o_loop_mask=0x02; STOP edge -> single o_stop; done 3 cycles later -> IDLE.
REQ-033 SHALL cover: REC held across reset release -> no o_start; REC and PLAY rising same cycle -> o_mode=1.
REQ-034 SHALL cover (MODE_CTRL_WDT_EN): STOP, no done for 1024 cycles -> one o_timeout pulse, IDLE.
